h3_dbus_bridge: RTL

H3_DBUS_BRIDGE -- requirements
Module: h3_dbus_bridge

---
 rtl/h3_dbus_bridge.sv | 88 ++++++++
 1 files changed

// File: rtl/h3_dbus_bridge.sv
// h3_dbus_bridge: core data-bus to SoC memory bridge with illegal-access and timeout error responses
// Ports:
//   clk, n_reset                  clock, asynchronous active-low reset
//   aph_req/aph_ready             core address-phase handshake
//   haddr, hsize, hwrite          address-phase attributes
//   wdata                         core write data (lanes pre-replicated)
//   dph_ready, dph_err, rdata     core data-phase completion, error, read data
//   mem_grant                     bus ownership (low while debug owns the bus)
//   mem_op, mem_adr, mem_wren, mem_di   SoC memory request
//   mem_do, mem_rdy               SoC read data and completion (mem_rdy = registered mem_op)
module h3_dbus_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        aph_req,
  output logic        aph_ready,
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic [31:0] wdata,
  output logic        dph_ready,
  output logic        dph_err,
  output logic [31:0] rdata,
  input  logic        mem_grant,
  output logic        mem_op,
  output logic [31:0] mem_adr,
  output logic [3:0]  mem_wren,
  output logic [31:0] mem_di,
  input  logic [31:0] mem_do,
  input  logic        mem_rdy
);
  localparam int CW = TIMEOUT < 2 ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
  state_t state, state_nx;
  logic [31:0] adr;
  logic [2:0] size;
  logic write;
  logic [CW-1:0] cnt;
  logic done, illegal, expire;
  logic [3:0] mask;
  assign done = state == DATA & mem_rdy;
  assign aph_ready = n_reset & aph_req & (state == IDLE | done);
  assign illegal = |haddr[31:18] | &haddr[17:16] | hsize > 3'd2 | (hsize == 3'd1 & haddr[0]) |
                   (hsize == 3'd2 & |haddr[1:0]) | (hwrite & haddr[17:16] == 2'b10);
  // The last waiting cycle before the counter would hit TIMEOUT ends the transaction;
  // the state leaves DATA, so mem_op drops and any late mem_rdy lands in ERR1.
  assign expire = TIMEOUT != 0 & state == DATA & ~mem_rdy & cnt == TLAST;
  assign mask = size == 3'd0 ? 4'b0001 << adr[1:0] : size == 3'd1 ? 4'b0011 << {adr[1], 1'b0} : 4'b1111;
  always_comb begin
    state_nx = state;
    dph_ready = 1'b0;
    dph_err = 1'b0;
    mem_op = 1'b0;
    mem_wren = 4'b0000;
    state_nx = aph_ready ? (illegal ? ERR1 : DATA)
             : state == DATA ? (mem_rdy ? IDLE : expire ? ERR1 : DATA)
             : state == ERR1 ? ERR2
             : state == ERR2 ? IDLE : state;
    dph_ready = done | state == ERR2;
    dph_err = state == ERR1 | state == ERR2;
    mem_op = state == DATA & mem_grant & ~mem_rdy;
    mem_wren = state == DATA & write ? mask : 4'b0000;
  end
  assign rdata = dph_ready & ~write ? mem_do : 32'h0;
  assign mem_adr = adr;
  assign mem_di = wdata;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      adr <= '0;
      size <= '0;
      write <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (aph_ready) begin
        adr <= haddr;
        size <= hsize;
        write <= hwrite;
        cnt <= '0;
      end else if (state == DATA & ~mem_rdy & cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
